// File: rtl/cpu_program_sequencer_if.sv
// Host-side bundle of the CPU program sequencer: program load
// handshake, session control and CPU/imem control outputs.
interface cpu_program_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              abort;
  logic [15:0]       run_cycles;
  logic [31:0]       instr_in;
  logic              instr_valid;
  logic              instr_last;
  logic              instr_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_load;
  logic              cpu_reset;
  logic              cpu_clk_en;
  logic [ADDR_W:0]   prog_len;
  logic              busy;
  logic              done;
  logic              err_overflow;

  modport master (
    output start,
    output abort,
    output run_cycles,
    output instr_in,
    output instr_valid,
    output instr_last,
    input  instr_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  cpu_load,
    input  cpu_reset,
    input  cpu_clk_en,
    input  prog_len,
    input  busy,
    input  done,
    input  err_overflow
  );

  modport slave (
    input  start,
    input  abort,
    input  run_cycles,
    input  instr_in,
    input  instr_valid,
    input  instr_last,
    output instr_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output cpu_load,
    output cpu_reset,
    output cpu_clk_en,
    output prog_len,
    output busy,
    output done,
    output err_overflow
  );
endinterface

// File: rtl/cpu_program_sequencer.sv
// CPU run-session controller: loads a program into imem, pulses
// CPU reset, runs the CPU for a cycle budget, then halts it.
module cpu_program_sequencer #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6,
  parameter int RST_CYCLES = 2
) (
  input logic                    clk,
  input logic                    Reset,
  cpu_program_sequencer_if.slave bus
);

  localparam int RC_W =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_END =
    RC_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0] TOP_A =
    (ADDR_W+1)'(IMEM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RST,
    RUN,
    DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   count_q;
  logic [RC_W-1:0]   rst_cnt_q;
  logic [15:0]       run_cnt_q;
  logic [15:0]       run_len_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              load_q;
  logic              cpu_rst_q;
  logic              en_q;
  logic [ADDR_W:0]   prog_len_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic accept;
  logic at_top;
  logic is_last;
  logic run_end;

  assign accept  = (state_q == LOAD) & ready_q & bus.instr_valid;
  assign at_top  = (count_q == TOP_A);
  assign is_last = bus.instr_last | at_top;
  // budget of zero means run until aborted
  assign run_end = (run_len_q != 16'd0) &&
                   (run_cnt_q == run_len_q - 16'd1);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rst_cnt_q  <= '0;
      run_cnt_q  <= '0;
      run_len_q  <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      load_q     <= 1'b0;
      cpu_rst_q  <= 1'b1;
      en_q       <= 1'b0;
      prog_len_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (bus.abort) begin
        state_q   <= IDLE;
        ready_q   <= 1'b0;
        load_q    <= 1'b0;
        cpu_rst_q <= 1'b1;
        en_q      <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (bus.start) begin
              state_q    <= LOAD;
              count_q    <= '0;
              prog_len_q <= '0;
              err_q      <= 1'b0;
              done_q     <= 1'b0;
              run_len_q  <= bus.run_cycles;
              ready_q    <= 1'b1;
              load_q     <= 1'b1;
              cpu_rst_q  <= 1'b0;
              en_q       <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
          LOAD: begin
            if (accept) begin
              we_q    <= 1'b1;
              addr_q  <= count_q[ADDR_W-1:0];
              wdata_q <= bus.instr_in;
              count_q <= count_q + 1'b1;
              if (is_last) begin
                state_q    <= RST;
                ready_q    <= 1'b0;
                load_q     <= 1'b0;
                cpu_rst_q  <= 1'b1;
                rst_cnt_q  <= '0;
                prog_len_q <= count_q + 1'b1;
                err_q      <= err_q |
                              (at_top & ~bus.instr_last);
              end
            end
          end
          RST: begin
            if (rst_cnt_q == RC_END) begin
              state_q   <= RUN;
              cpu_rst_q <= 1'b0;
              en_q      <= 1'b1;
              run_cnt_q <= '0;
            end else begin
              rst_cnt_q <= rst_cnt_q + 1'b1;
            end
          end
          RUN: begin
            run_cnt_q <= run_cnt_q + 16'd1;
            if (run_end) begin
              state_q <= DONE;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.instr_ready  = ready_q;
  assign bus.imem_we      = we_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.cpu_load     = load_q;
  assign bus.cpu_reset    = cpu_rst_q;
  assign bus.cpu_clk_en   = en_q;
  assign bus.prog_len     = prog_len_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Scoreboard bench: stimulus queues expected imem writes, negedge
// monitors pop and compare them against what the DUTs emit.
module tb_cpu_program_sequencer;

  logic clk;
  logic Reset;
  int   cyc;
  int   total;
  int   bad;

  cpu_program_sequencer_if #(.ADDR_W(6)) b ();
  cpu_program_sequencer_if #(.ADDR_W(6)) b4 ();

  cpu_program_sequencer #(
    .IMEM_DEPTH(64), .ADDR_W(6), .RST_CYCLES(2)
  ) dut (
    .clk(clk), .Reset(Reset), .bus(b)
  );

  cpu_program_sequencer #(
    .IMEM_DEPTH(4), .ADDR_W(6), .RST_CYCLES(2)
  ) dut4 (
    .clk(clk), .Reset(Reset), .bus(b4)
  );

  typedef struct {
    int          c;
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        v;
    logic        l;
    logic [31:0] d;
  } stim_t;

  wr_t   q[$];
  wr_t   q4[$];
  stim_t vec[$];

  logic [31:0] prog1 [11] = '{
    32'h200101A7, 32'h00000013, 32'h00108093,
    32'h00210113, 32'h003181B3, 32'h40208233,
    32'h0041A2B3, 32'h00529313, 32'h0062D393,
    32'hFFF30313, 32'h00E24020
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1);
  end

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (b.imem_we === 1'b1) begin
      if (q.size() == 0) begin
        chk("wr_unexpected", {26'd0, b.imem_addr}, 32'hFFFF);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_cyc", cyc, e.c);
        chk("wr_addr", {26'd0, b.imem_addr}, {26'd0, e.a});
        chk("wr_data", b.imem_wdata, e.d);
      end
    end
  end

  always @(negedge clk) begin
    if (b4.imem_we === 1'b1) begin
      if (q4.size() == 0) begin
        chk("wr4_unexpected", {26'd0, b4.imem_addr}, 32'hFFFF);
      end else begin
        wr_t e;
        e = q4.pop_front();
        chk("wr4_cyc", cyc, e.c);
        chk("wr4_addr", {26'd0, b4.imem_addr}, {26'd0, e.a});
        chk("wr4_data", b4.imem_wdata, e.d);
      end
    end
  end

  task automatic begin_load(input logic [15:0] rc,
                            input string tag);
    b.start = 1'b1;
    b.run_cycles = rc;
    step();
    b.start = 1'b0;
    chk({tag, "_entry_done"}, b.done, 0);
    chk({tag, "_entry_load"}, b.cpu_load, 1);
    chk({tag, "_entry_ready"}, b.instr_ready, 1);
    chk({tag, "_entry_busy"}, b.busy, 1);
    chk({tag, "_entry_rst"}, b.cpu_reset, 0);
  endtask

  task automatic load_vec(input string tag);
    logic [5:0] a;
    a = '0;
    foreach (vec[i]) begin
      b.instr_valid = vec[i].v;
      b.instr_last  = vec[i].l;
      b.instr_in    = vec[i].d;
      if (vec[i].v) begin
        q.push_back('{c: cyc + 1, a: a, d: vec[i].d});
        a++;
      end
      step();
    end
    b.instr_valid = 1'b0;
    b.instr_last  = 1'b0;
    chk({tag, "_post_ready"}, b.instr_ready, 0);
    chk({tag, "_post_rst"}, b.cpu_reset, 1);
    chk({tag, "_post_load"}, b.cpu_load, 0);
  endtask

  task automatic session(input logic [15:0] rc,
                         input int len,
                         input string tag);
    int nrst;
    int nen;
    int k;
    begin_load(rc, tag);
    load_vec(tag);
    nrst = 0;
    nen = 0;
    k = 0;
    while (b.done !== 1'b1 && k < 200) begin
      if (b.cpu_reset) nrst++;
      if (b.cpu_clk_en) nen++;
      step();
      k++;
    end
    chk({tag, "_done"}, b.done, 1);
    chk({tag, "_rst_cycles"}, nrst, 2);
    chk({tag, "_run_cycles"}, nen, rc);
    chk({tag, "_busy"}, b.busy, 0);
    chk({tag, "_en_off"}, b.cpu_clk_en, 0);
    chk({tag, "_rst_off"}, b.cpu_reset, 0);
    chk({tag, "_prog_len"}, b.prog_len, len);
    chk({tag, "_err"}, b.err_overflow, 0);
  endtask

  initial begin
    int k;
    total = 0;
    bad = 0;
    cyc = 0;
    Reset = 1'b0;
    {b.start, b.abort, b.instr_valid, b.instr_last} = '0;
    b.run_cycles = '0;
    b.instr_in = '0;
    {b4.start, b4.abort, b4.instr_valid, b4.instr_last} = '0;
    b4.run_cycles = '0;
    b4.instr_in = '0;
    repeat (3) step();

    chk("rst_cpu_reset", b.cpu_reset, 1);
    chk("rst_outs", {b.instr_ready, b.imem_we, b.cpu_load,
        b.cpu_clk_en, b.busy, b.done, b.err_overflow}, 0);
    chk("rst_prog_len", b.prog_len, 0);
    Reset = 1'b1;
    step();

    // 11-word program, budget 10
    vec.delete();
    foreach (prog1[i])
      vec.push_back('{v: 1'b1, l: (i == 10), d: prog1[i]});
    session(16'd10, 11, "p11");

    // gappy handshake from DONE
    vec.delete();
    vec.push_back('{v: 1'b1, l: 1'b0, d: 32'hAAAA0001});
    vec.push_back('{v: 1'b0, l: 1'b0, d: 32'hBBBB0002});
    vec.push_back('{v: 1'b0, l: 1'b1, d: 32'hDEADBEEF});
    vec.push_back('{v: 1'b1, l: 1'b0, d: 32'hBBBB0002});
    vec.push_back('{v: 1'b1, l: 1'b1, d: 32'hCCCC0003});
    session(16'd3, 3, "gap");

    // one-word program from DONE
    vec.delete();
    vec.push_back('{v: 1'b1, l: 1'b1, d: 32'h00000073});
    session(16'd3, 1, "one");

    // abort in RUN cycle 5, unbounded budget
    vec.delete();
    vec.push_back('{v: 1'b1, l: 1'b0, d: 32'h11110000});
    vec.push_back('{v: 1'b1, l: 1'b1, d: 32'h22220000});
    begin_load(16'd0, "abt");
    load_vec("abt");
    k = 0;
    while (b.cpu_clk_en !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("abt_run_seen", b.cpu_clk_en, 1);
    repeat (4) step();
    chk("abt_run5_en", b.cpu_clk_en, 1);
    b.abort = 1'b1;
    step();
    b.abort = 1'b0;
    chk("abt_en", b.cpu_clk_en, 0);
    chk("abt_rst", b.cpu_reset, 1);
    chk("abt_done", b.done, 0);
    chk("abt_busy", b.busy, 0);
    step();
    chk("abt_stays_idle", b.busy, 0);

    // reset low the cycle after an accept
    begin_load(16'd5, "rml");
    b.instr_valid = 1'b1;
    b.instr_in = 32'h5A5A0000;
    q.push_back('{c: cyc + 1, a: 6'd0, d: 32'h5A5A0000});
    step();
    b.instr_in = 32'h5A5A0001;
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    chk("rml_we", b.imem_we, 0);
    chk("rml_cpu_reset", b.cpu_reset, 1);
    chk("rml_outs", {b.instr_ready, b.cpu_load,
        b.cpu_clk_en, b.busy, b.done, b.err_overflow}, 0);
    chk("rml_prog_len", b.prog_len, 0);
    repeat (2) step();
    chk("rml_no_start_ready", b.instr_ready, 0);
    chk("rml_no_start_busy", b.busy, 0);
    b.instr_valid = 1'b0;

    // overflow on a 4-deep memory
    b4.start = 1'b1;
    b4.run_cycles = 16'd2;
    step();
    b4.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ovf_ready%0d", i), b4.instr_ready, (i < 4));
      if (i >= 4) begin
        chk($sformatf("ovf_err%0d", i), b4.err_overflow, 1);
        chk($sformatf("ovf_rst%0d", i), b4.cpu_reset, 1);
      end
      b4.instr_valid = 1'b1;
      b4.instr_in = 32'hA0000000 + i;
      if (i < 4)
        q4.push_back('{c: cyc + 1, a: 6'(i),
                       d: 32'hA0000000 + i});
      step();
    end
    b4.instr_valid = 1'b0;
    k = 0;
    while (b4.done !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    chk("ovf_done", b4.done, 1);
    chk("ovf_prog_len", b4.prog_len, 4);
    chk("ovf_err_sticky", b4.err_overflow, 1);

    repeat (3) step();
    chk("q_empty", q.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_program_sequencer.md
Name: cpu_program_sequencer

Overview:
- Sequences a CPU run session: accepts a program word-by-word from a host over a valid/ready handshake and writes it into instruction memory.
- Holds the CPU in load mode during the load, then pulses CPU reset, runs the CPU for a programmed cycle budget and halts it.
- Replaces hand-driven LoadInstructions/Reset/Instruction sequencing with one controller; sits between host/bench and the CPU top.

Parameters:
- IMEM_DEPTH, 64, instruction memory depth in words.
- ADDR_W, 6, instruction memory address width; IMEM_DEPTH <= 2**ADDR_W.
- RST_CYCLES, 2, cycles cpu_reset is held high after load; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- start  in  1  begin load session; sampled in IDLE/DONE only.
- abort  in  1  terminate any session; highest priority.
- run_cycles  in  16  CPU run budget; sampled on accepted start; 0 = run until abort.
- instr_in  in  32  program word.
- instr_valid  in  1  instr_in valid.
- instr_last  in  1  marks final program word; qualified by instr_valid.
- instr_ready  out  1  sequencer accepts a word this cycle.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  instruction memory write address.
- imem_wdata  out  32  instruction memory write data.
- cpu_load  out  1  drives CPU LoadInstructions.
- cpu_reset  out  1  drives CPU Reset (active-high at CPU).
- cpu_clk_en  out  1  CPU clock enable / run gate.
- prog_len  out  ADDR_W+1  number of words loaded in the last session.
- busy  out  1  state is LOAD, RST or RUN.
- done  out  1  run completed.
- err_overflow  out  1  program hit IMEM_DEPTH without instr_last.

Behaviour:
- Reset low at an edge: state=IDLE; all outputs 0 except cpu_reset=1; counters cleared. A pending memory write is dropped.
- States: IDLE, LOAD, RST, RUN, DONE. All outputs registered.
- IDLE: cpu_reset=1, cpu_load=0, cpu_clk_en=0, instr_ready=0.
  - start -> LOAD. Clears word count, prog_len, err_overflow and done; latches run_cycles.
- LOAD: cpu_load=1, cpu_reset=0, instr_ready=1.
  - Accept = instr_valid && instr_ready.
  - One cycle after an accept: imem_we=1, imem_addr=count, imem_wdata=word; count increments.
  - No accept -> imem_we=0 next cycle.
  - Accept with instr_last -> RST next cycle; instr_ready drops in that same next cycle; the final write still issues.
  - Accept at address IMEM_DEPTH-1 without instr_last -> err_overflow=1 (sticky), treated as last.
  - prog_len = count after the final write.
- RST: cpu_load=0, cpu_reset=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: cpu_reset=0, cpu_clk_en=1.
  - Run counter counts cycles spent in RUN.
  - After exactly run_cycles cycles -> DONE (cpu_clk_en high for run_cycles cycles).
  - run_cycles=0: stay in RUN until abort.
- DONE: cpu_clk_en=0, cpu_reset=0, done=1, memory contents retained.
  - start -> LOAD (new session; done cleared); abort -> IDLE.
- abort in LOAD/RST/RUN/DONE -> IDLE next cycle. Abort beats start, instr_last and run expiry in the same cycle; a write registered in that cycle is suppressed.
- start outside IDLE/DONE: ignored. instr_valid outside LOAD: ignored, no write.
- busy = (state in LOAD, RST, RUN).

Test Plan:
- Load 11 words, first 0x200101A7, last 0x00E24020 with instr_last, run_cycles=10.
  - Expect 11 writes at addr 0..10, each one cycle after its accept; prog_len=11.
  - cpu_reset high 2 cycles; cpu_clk_en high exactly 10 cycles; done=1; busy=0.
- Gappy handshake: instr_valid toggled 1,0,0,1,1 with data A,B,C.
  - Expect exactly 3 writes at addresses 0,1,2 with data A,B,C; no writes in idle gaps.
- Overflow: IMEM_DEPTH=4, send 6 words with no instr_last.
  - Expect 4 writes, err_overflow=1, prog_len=4, transition to RST after the 4th accept, words 5–6 not accepted.
- Abort during RUN, run_cycles=0, at RUN cycle 5.
  - Expect IDLE next cycle, cpu_clk_en=0, cpu_reset=1, done=0.
- Reset low mid-LOAD on the cycle after an accept.
  - Expect no imem_we, all outputs at reset values, and start required for the next session.
- DONE then start with a 1-word program, run_cycles=3.
  - Expect done cleared on entry to LOAD, prog_len=1, cpu_clk_en high 3 cycles.
